axi_alu_arbiter: RTL and testbench

AXI_ALU_ARBITER -- requirements
Module: axi_alu_arbiter

---
 rtl/axi_alu_arbiter.sv | 128 ++++++++++++
 tb/tb_axi_alu_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_alu_arbiter.sv
// Two-requester round-robin front end for a small registered ALU. Each transaction is two
// operand beats (A with opcode, then B) from the granted requester, then one result beat.
module axi_alu_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RES_W  = DATA_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [1:0]        op0,
  input  logic              wvalid0,
  output logic              wready0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        op1,
  input  logic              wvalid1,
  output logic              wready1,
  output logic [RES_W-1:0]  rdata,
  output logic              rid,
  output logic              rvalid,
  input  logic              rready,
  output logic              busy
);

  typedef enum logic [2:0] {StIdle, StOpA, StOpB, StExec, StResp} state_e;

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]         opc_q, opc_d;
  logic [RES_W-1:0]   rdata_q, rdata_d;
  logic               rid_q, rid_d;

  logic               wvalid_g;
  logic [DATA_W-1:0]  wdata_g;
  logic [1:0]         op_g;
  logic [RES_W-1:0]   alu_res;

  assign wvalid_g = grant_q ? wvalid1 : wvalid0;
  assign wdata_g  = grant_q ? wdata1 : wdata0;
  assign op_g     = grant_q ? op1 : op0;

  // Bit DATA_W of the widened subtraction is exactly the borrow (A < B).
  always_comb begin
    alu_res = '0;
    unique case (opc_q)
      2'b00: alu_res = {1'b0, a_q} + {1'b0, b_q};
      2'b01: alu_res = {1'b0, a_q} - {1'b0, b_q};
      2'b10: alu_res = {1'b0, a_q & b_q};
      2'b11: alu_res = {1'b0, a_q ^ b_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    opc_d   = opc_q;
    rdata_d = rdata_q;
    rid_d   = rid_q;
    case (state_q)
      StIdle: begin
        if (wvalid0 || wvalid1) begin
          // On a tie the requester not served last wins; otherwise whoever is asking.
          grant_d = (wvalid0 && wvalid1) ? ~last_q : wvalid1;
          state_d = StOpA;
        end
      end
      StOpA: begin
        if (wvalid_g) begin
          a_d     = wdata_g;
          opc_d   = op_g;
          state_d = StOpB;
        end
      end
      StOpB: begin
        if (wvalid_g) begin
          b_d     = wdata_g;
          state_d = StExec;
        end
      end
      StExec: begin
        rdata_d = alu_res;
        rid_d   = grant_q;
        state_d = StResp;
      end
      StResp: begin
        if (rready) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= 2'b00;
      rdata_q <= '0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opc_q   <= opc_d;
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
    end
  end

  assign wready0 = (state_q == StOpA || state_q == StOpB) && !grant_q;
  assign wready1 = (state_q == StOpA || state_q == StOpB) && grant_q;
  assign rvalid  = (state_q == StResp);
  assign busy    = (state_q != StIdle);
  assign rdata   = rdata_q;
  assign rid     = rid_q;

endmodule

// File: tb/tb_axi_alu_arbiter.sv
// Bench for axi_alu_arbiter: directed scenarios plus randomized two-requester traffic
// scored against a per-requester queue of arithmetic reference results.
module tb_axi_alu_arbiter;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = DATA_W + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [1:0]        op0, op1;
  logic              wvalid0, wvalid1, wready0, wready1;
  logic [RES_W-1:0]  rdata;
  logic              rid, rvalid, rready, busy;

  int checks = 0;
  int failures = 0;
  logic [RES_W-1:0] exp_q0[$];
  logic [RES_W-1:0] exp_q1[$];

  always #5 clk = ~clk;

  axi_alu_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .wdata0(wdata0), .op0(op0), .wvalid0(wvalid0), .wready0(wready0),
    .wdata1(wdata1), .op1(op1), .wvalid1(wvalid1), .wready1(wready1),
    .rdata(rdata), .rid(rid), .rvalid(rvalid), .rready(rready), .busy(busy)
  );

  function automatic logic [RES_W-1:0] alu_ref(input logic [1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    int ia, ib, r, m;
    ia = int'(a);
    ib = int'(b);
    m  = 1 << DATA_W;
    case (op)
      2'd0: r = ia + ib;
      2'd1: r = (ia >= ib) ? ia - ib : m + (m + ia - ib);
      2'd2: r = ia & ib;
      default: r = ia ^ ib;
    endcase
    return RES_W'(r);
  endfunction

  task automatic set_beat(input int r, input logic v, input logic [DATA_W-1:0] d,
                          input logic [1:0] o);
    if (r == 0) begin wvalid0 = v; wdata0 = d; op0 = o; end
    else begin wvalid1 = v; wdata1 = d; op1 = o; end
  endtask

  // Returns at posedge+1 after the edge on which the current beat was taken.
  task automatic wait_accept(input int r);
    int n = 0;
    forever begin
      @(negedge clk);
      if (((r == 0) ? wready0 : wready1) === 1'b1) break;
      n++;
      if (n > 300) begin
        checks++; failures++;
        $display("FAIL accept_timeout: requester %0d got no wready within %0d cycles", r, n);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_txn(input int r, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [1:0] op, input int gap);
    set_beat(r, 1'b1, a, op);
    wait_accept(r);
    if (gap > 0) begin
      set_beat(r, 1'b0, b, op);
      repeat (gap) @(posedge clk);
      #1;
    end
    set_beat(r, 1'b1, b, op);
    wait_accept(r);
    set_beat(r, 1'b0, b, op);
  endtask

  task automatic get_result(output logic [RES_W-1:0] d, output logic id, output bit ok);
    int n = 0;
    ok = 1'b0; d = '0; id = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk); n++;
      if (rvalid === 1'b1 && rready === 1'b1) begin ok = 1'b1; d = rdata; id = rid; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rready = 1'b0;
    set_beat(0, 1'b0, '0, 2'b00);
    set_beat(1, 1'b0, '0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wready0 !== 1'b0) begin failures++; $display("FAIL reset_wready0: got %b want 0", wready0); end
    checks++; if (wready1 !== 1'b0) begin failures++; $display("FAIL reset_wready1: got %b want 0", wready1); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    checks++; if (rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (rid !== 1'b0) begin failures++; $display("FAIL reset_rid: got %b want 0", rid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    int first = -1;
    int nvalid = 0;
    logic [RES_W-1:0] d = '0;
    logic id = 1'b1;
    rready = 1'b1;
    fork
      drive_txn(0, 8'hF0, 8'h20, 2'b00, 0);
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (rvalid === 1'b1) begin
          if (first < 0) begin first = c; d = rdata; id = rid; end
          nvalid++;
        end
      end
    join
    @(posedge clk); #1;
    // Cycle 1 is the IDLE grant cycle, so the result is visible in cycle 5.
    checks++; if (first != 5) begin failures++; $display("FAIL single_latency: got cycle %0d want 5", first); end
    checks++; if (nvalid != 1) begin failures++; $display("FAIL single_rvalid_len: got %0d want 1", nvalid); end
    checks++; if (d !== 9'h110) begin failures++; $display("FAIL single_rdata: got %h want 110", d); end
    checks++; if (id !== 1'b0) begin failures++; $display("FAIL single_rid: got %b want 0", id); end
  endtask

  task automatic test_alu_ops();
    logic [DATA_W-1:0] ta[3] = '{8'h05, 8'h3C, 8'h3C};
    logic [DATA_W-1:0] tb[3] = '{8'h07, 8'h0F, 8'h0F};
    logic [1:0]        to[3] = '{2'b01, 2'b10, 2'b11};
    logic [RES_W-1:0]  te[3] = '{9'h1FE, 9'h00C, 9'h033};
    logic [RES_W-1:0]  d;
    logic              id;
    bit                ok;
    rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fork
        drive_txn(1, ta[i], tb[i], to[i], 0);
        get_result(d, id, ok);
      join
      checks++; if (d !== te[i]) begin failures++; $display("FAIL alu_op%0d_rdata: got %h want %h", to[i], d, te[i]); end
      checks++; if (!ok || id !== 1'b1) begin failures++; $display("FAIL alu_op%0d_rid: got %b ok=%0d want 1", to[i], id, ok); end
    end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] a[2][2], b[2][2];
    logic [1:0]        o[2][2];
    int pend[2] = '{2, 2};
    int idx[2] = '{0, 0};
    int last_m = 1;
    int bad = 0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) begin
        a[r][k] = DATA_W'($urandom); b[r][k] = DATA_W'($urandom); o[r][k] = 2'($urandom);
      end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; rready = 1'b1;
    fork
      for (int k = 0; k < 2; k++) drive_txn(0, a[0][k], b[0][k], o[0][k], 0);
      for (int k = 0; k < 2; k++) drive_txn(1, a[1][k], b[1][k], o[1][k], 0);
      for (int i = 0; i < 4; i++) begin
        int g, n;
        bit got;
        logic [RES_W-1:0] d, e;
        logic id;
        g = (pend[0] > 0 && pend[1] > 0) ? 1 - last_m : ((pend[0] > 0) ? 0 : 1);
        n = 0; got = 1'b0; d = '0; id = 1'b0;
        while (!got && n < 300) begin
          @(negedge clk); n++;
          if ((g == 0 && wready1 === 1'b1) || (g == 1 && wready0 === 1'b1)) bad++;
          if (rvalid === 1'b1 && rready === 1'b1) begin got = 1'b1; d = rdata; id = rid; end
        end
        @(posedge clk); #1;
        e = alu_ref(o[g][idx[g]], a[g][idx[g]], b[g][idx[g]]);
        checks++; if (!got || id !== 1'(g)) begin failures++; $display("FAIL rr_rid%0d: got %b want %0d", i, id, g); end
        checks++; if (d !== e) begin failures++; $display("FAIL rr_rdata%0d: got %h want %h", i, d, e); end
        pend[g]--; idx[g]++; last_m = g;
      end
    join
    checks++; if (bad != 0) begin failures++; $display("FAIL rr_idle_wready: got %0d cycles want 0", bad); end
  endtask

  task automatic test_backpressure();
    logic [RES_W-1:0] d, d2;
    logic id2;
    bit ok;
    int n = 0;
    int stable_bad = 0;
    logic rv_after = 1'b1;
    rready = 1'b0;
    drive_txn(0, 8'h81, 8'h92, 2'b00, 0);
    fork
      drive_txn(1, 8'h44, 8'h11, 2'b11, 0);
      begin
        do begin @(negedge clk); n++; end while (rvalid !== 1'b1 && n < 50);
        d = rdata;
        for (int c = 0; c < 3; c++) begin
          if (c == 2) begin @(posedge clk); #1; rready = 1'b1; end
          else begin @(posedge clk); #1; end
          @(negedge clk);
          if (rvalid !== 1'b1 || rdata !== d || rid !== 1'b0 || wready1 !== 1'b0 || busy !== 1'b1)
            stable_bad++;
        end
        @(posedge clk); #1;
        rv_after = rvalid;
        get_result(d2, id2, ok);
      end
    join
    checks++; if (d !== 9'h113) begin failures++; $display("FAIL bp_rdata: got %h want 113", d); end
    checks++; if (stable_bad != 0) begin failures++; $display("FAIL bp_stable: got %0d bad cycles want 0", stable_bad); end
    checks++; if (rv_after !== 1'b0) begin failures++; $display("FAIL bp_handshake: rvalid got %b want 0", rv_after); end
    checks++; if (!ok || id2 !== 1'b1) begin failures++; $display("FAIL bp_next_rid: got %b want 1", id2); end
    checks++; if (d2 !== 9'h055) begin failures++; $display("FAIL bp_next_rdata: got %h want 055", d2); end
  endtask

  task automatic test_wvalid_gap();
    logic [RES_W-1:0] d = '0, d2;
    logic id = 1'b1, id2;
    bit ok;
    int w0cnt = 0;
    int bad = 0;
    rready = 1'b1;
    fork
      drive_txn(0, 8'hC3, 8'h5A, 2'b01, 2);
      begin @(posedge clk); #1; drive_txn(1, 8'h12, 8'h34, 2'b00, 0); end
      begin
        for (int n = 0; n < 300; n++) begin
          @(negedge clk);
          if (wready0 === 1'b1) w0cnt++;
          if (wready1 === 1'b1) bad++;
          if (rvalid === 1'b1) begin d = rdata; id = rid; break; end
        end
        @(posedge clk); #1;
        get_result(d2, id2, ok);
      end
    join
    checks++; if (w0cnt != 4) begin failures++; $display("FAIL gap_wready0_cycles: got %0d want 4", w0cnt); end
    checks++; if (bad != 0) begin failures++; $display("FAIL gap_req1_blocked: got %0d cycles want 0", bad); end
    checks++; if (d !== 9'h069) begin failures++; $display("FAIL gap_rdata: got %h want 069", d); end
    checks++; if (id !== 1'b0) begin failures++; $display("FAIL gap_rid: got %b want 0", id); end
    checks++; if (!ok || id2 !== 1'b1) begin failures++; $display("FAIL gap_next_rid: got %b want 1", id2); end
    checks++; if (d2 !== 9'h046) begin failures++; $display("FAIL gap_next_rdata: got %h want 046", d2); end
  endtask

  task automatic test_reset_mid();
    logic [RES_W-1:0] d, d2;
    logic id, id2;
    bit ok, ok2;
    int stray = 0;
    rready = 1'b1;
    set_beat(0, 1'b1, 8'h77, 2'b00);
    wait_accept(0);
    set_beat(0, 1'b1, 8'h11, 2'b00);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (wready0 !== 1'b0) begin failures++; $display("FAIL rmid_wready0: got %b want 0", wready0); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rmid_rvalid: got %b want 0", rvalid); end
    checks++; if (rdata !== '0) begin failures++; $display("FAIL rmid_rdata: got %h want 0", rdata); end
    checks++; if (rid !== 1'b0) begin failures++; $display("FAIL rmid_rid: got %b want 0", rid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
    reset = 1'b1;
    set_beat(0, 1'b0, '0, 2'b00);
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (rvalid === 1'b1) stray++; end
    @(posedge clk); #1;
    checks++; if (stray != 0) begin failures++; $display("FAIL rmid_no_partial: got %0d rvalid cycles want 0", stray); end
    // Pointer is back at requester 1, so requester 0 wins this tie.
    fork
      drive_txn(0, 8'h0F, 8'h01, 2'b11, 0);
      drive_txn(1, 8'hFF, 8'h01, 2'b00, 0);
      begin get_result(d, id, ok); get_result(d2, id2, ok2); end
    join
    checks++; if (!ok || id !== 1'b0) begin failures++; $display("FAIL rmid_tie_first_rid: got %b want 0", id); end
    checks++; if (d !== 9'h00E) begin failures++; $display("FAIL rmid_tie_first_rdata: got %h want 00e", d); end
    checks++; if (!ok2 || id2 !== 1'b1) begin failures++; $display("FAIL rmid_req1_rid: got %b want 1", id2); end
    checks++; if (d2 !== 9'h100) begin failures++; $display("FAIL rmid_req1_rdata: got %h want 100", d2); end
  endtask

  task automatic random_requester(input int r, input int n);
    logic [DATA_W-1:0] a, b;
    logic [1:0] o;
    int idle;
    for (int k = 0; k < n; k++) begin
      a = DATA_W'($urandom); b = DATA_W'($urandom); o = 2'($urandom);
      if (r == 0) exp_q0.push_back(alu_ref(o, a, b));
      else exp_q1.push_back(alu_ref(o, a, b));
      drive_txn(r, a, b, o, $urandom_range(0, 2));
      idle = $urandom_range(0, 3);
      if (idle > 0) begin repeat (idle) @(posedge clk); #1; end
    end
  endtask

  task automatic test_random();
    localparam int N = 12;
    bit done = 1'b0;
    int got = 0;
    exp_q0.delete(); exp_q1.delete();
    fork
      random_requester(0, N);
      random_requester(1, N);
      while (!done) begin
        @(posedge clk); #1;
        if (!done) rready = ($urandom_range(0, 3) != 0);
      end
      begin
        logic [RES_W-1:0] e;
        for (int n = 0; n < 8000 && got < 2 * N; n++) begin
          @(negedge clk);
          if (rvalid === 1'b1 && rready === 1'b1) begin
            got++;
            if (rid === 1'b0 && exp_q0.size() > 0) e = exp_q0.pop_front();
            else if (rid === 1'b1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            else e = 'x;
            checks++;
            if (rdata !== e) begin failures++; $display("FAIL rand_rdata%0d: rid %b got %h want %h", got, rid, rdata, e); end
          end
        end
        done = 1'b1;
      end
    join
    @(posedge clk); #1;
    rready = 1'b1;
    checks++; if (got != 2 * N) begin failures++; $display("FAIL rand_count: got %0d results want %0d", got, 2 * N); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alu_ops();
    test_round_robin();
    test_backpressure();
    test_wvalid_gap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
